div_rr_sched: RTL and testbench



---
 rtl/div_rr_sched.sv | 101 ++++++++++
 tb/tb_div_rr_sched.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/div_rr_sched.sv
// div_rr_sched: round-robin scheduler sharing one multicycle unsigned divider among 4 requesters
module div_rr_sched #(
  parameter int DATAWIDTH  = 8,
  parameter int DIV_CYCLES = 2
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [3:0]             req,
  input  logic [4*DATAWIDTH-1:0] a,
  input  logic [4*DATAWIDTH-1:0] b,
  output logic [3:0]             grant,
  output logic                   busy,
  output logic [3:0]             done,
  output logic [DATAWIDTH-1:0]   quot,
  output logic                   dz
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam logic [7:0] CNT_INIT = 8'(DIV_CYCLES - 1);
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, g, g_n, win;
  logic found;
  logic [7:0] cnt, cnt_n;
  logic [DATAWIDTH-1:0] a_reg, b_reg, a_n, b_n, quot_n, div_q;
  logic [3:0] grant_n, done_n;
  logic dz_n;
  assign busy = (state != IDLE);
  assign div_q = (b_reg == '0) ? '1 : a_reg / b_reg;
  // first requesting index at or after ptr, wrapping mod 4
  always_comb begin
    win = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[ptr + 2'(k)]) begin
        win = ptr + 2'(k);
        found = 1'b1;
      end
    end
  end
  // next-state and datapath updates; operands and grant stay frozen outside IDLE
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    g_n = g;
    grant_n = grant;
    done_n = 4'b0;
    a_n = a_reg;
    b_n = b_reg;
    cnt_n = cnt;
    quot_n = quot;
    dz_n = dz;
    case (state)
      IDLE: if (found) begin
        state_n = EXEC;
        g_n = win;
        grant_n = 4'b1 << win;
        a_n = a[win*DATAWIDTH +: DATAWIDTH];
        b_n = b[win*DATAWIDTH +: DATAWIDTH];
        cnt_n = CNT_INIT;
      end
      EXEC: if (cnt != 8'd0) cnt_n = cnt - 8'd1;
      else begin
        state_n = DONE;
        quot_n = div_q;
        dz_n = (b_reg == '0);
        done_n = 4'b1 << g;
      end
      DONE: begin
        state_n = IDLE;
        grant_n = 4'b0;
        ptr_n = g + 2'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  // state register; reset aborts any operation in flight
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      ptr <= 2'd0;
      g <= 2'd0;
      grant <= 4'b0;
      done <= 4'b0;
      a_reg <= '0;
      b_reg <= '0;
      cnt <= 8'd0;
      quot <= '0;
      dz <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      g <= g_n;
      grant <= grant_n;
      done <= done_n;
      a_reg <= a_n;
      b_reg <= b_n;
      cnt <= cnt_n;
      quot <= quot_n;
      dz <= dz_n;
    end
  end
endmodule

// File: tb/tb_div_rr_sched.sv
// tb_div_rr_sched: scoreboard bench for the round-robin divider scheduler
module tb_div_rr_sched;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [3:0] req = 4'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0] grant, done;
  logic busy, dz;
  logic [7:0] quot;
  int tests = 0;
  int fails = 0;
  typedef struct packed {logic [3:0] d; logic [7:0] q; logic z;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  div_rr_sched #(.DATAWIDTH(8), .DIV_CYCLES(2)) dut (
    .Clk(Clk), .Rst(Rst), .req(req), .a(a), .b(b),
    .grant(grant), .busy(busy), .done(done), .quot(quot), .dz(dz)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_grant"}, 32'(grant), 32'd0);
    chk({n, "_busy"}, 32'(busy), 32'd0);
    chk({n, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic set_op(input int i, input int av, input int bv);
    a[i*8 +: 8] = 8'(av);
    b[i*8 +: 8] = 8'(bv);
  endtask

  task automatic push(input int i, input int q, input int z);
    sb.push_back({4'(1 << i), 8'(q), 1'(z)});
  endtask

  task automatic wait_done(output int w);
    w = -1;
    for (int n = 0; n < 30 && w < 0; n++) begin
      @(negedge Clk);
      for (int k = 0; k < 4; k++) if (done[k]) w = k;
    end
    if (w < 0) begin
      tests++;
      fails++;
      $display("FAIL wait_done timeout got=none required=done pulse at %0t", $time);
    end
  endtask

  task automatic wait_grant(output int w);
    w = -1;
    for (int n = 0; n < 30 && w < 0; n++) begin
      @(negedge Clk);
      for (int k = 0; k < 4; k++) if (grant[k]) w = k;
    end
    if (w < 0) begin
      tests++;
      fails++;
      $display("FAIL wait_grant timeout got=none required=grant at %0t", $time);
    end
  endtask

  task automatic do_op(input int i, input int av, input int bv, input int q, input int z);
    int w;
    set_op(i, av, bv);
    push(i, q, z);
    @(posedge Clk); #1 req[i] = 1'b1;
    wait_done(w);
    chk("op_winner", 32'(w), 32'(i));
    @(posedge Clk); #1 req[i] = 1'b0;
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge Clk) begin
    if (done != 4'b0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done got=%b required=none at %0t", done, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("mon_done", 32'(done), 32'(mon_e.d));
        chk("mon_quot", 32'(quot), 32'(mon_e.q));
        chk("mon_dz", 32'(dz), 32'(mon_e.z));
        chk("mon_grant", 32'(grant), 32'(mon_e.d));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge Clk);
      chk_zero("rst_idle");
      chk("rst_quot", 32'(quot), 32'd0);
      chk("rst_dz", 32'(dz), 32'd0);
    end
    // single op with exact latency
    @(posedge Clk); #1 set_op(2, 200, 7);
    req = 4'b0100;
    push(2, 28, 0);
    @(negedge Clk); chk("pre_grant", 32'(grant), 32'd0);
    @(negedge Clk); chk("c1_grant", 32'(grant), 32'h4); chk("c1_busy", 32'(busy), 32'd1); chk("c1_done", 32'(done), 32'd0);
    @(negedge Clk); chk("c2_grant", 32'(grant), 32'h4); chk("c2_busy", 32'(busy), 32'd1); chk("c2_done", 32'(done), 32'd0);
    @(negedge Clk); chk("c3_done", 32'(done), 32'h4); chk("c3_busy", 32'(busy), 32'd1);
    @(posedge Clk); #1 req = 4'b0;
    @(negedge Clk); chk_zero("c4"); chk("c4_quot_hold", 32'(quot), 32'd28);
    // divide by zero, then dz cleared by a normal op
    do_op(1, 55, 0, 255, 1);
    do_op(0, 9, 3, 3, 0);
    // round-robin from ptr=0
    @(posedge Clk); #1 Rst = 1'b1;
    @(posedge Clk); #1 Rst = 1'b0;
    set_op(0, 100, 3); set_op(1, 50, 5); set_op(2, 81, 9); set_op(3, 255, 16);
    push(0, 33, 0); push(1, 10, 0); push(2, 9, 0); push(3, 15, 0); push(0, 33, 0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(w);
      chk("rr_order", 32'(w), 32'(k % 4));
      @(posedge Clk); #1 if (w >= 0) req[w] = 1'b0;
      if (k == 4) req = 4'b0;
      else begin
        @(posedge Clk); #1 if (w >= 0) req[w] = 1'b1;
      end
    end
    // operand isolation and req drop during EXEC
    set_op(3, 100, 10);
    push(3, 10, 0);
    @(posedge Clk); #1 req[3] = 1'b1;
    wait_grant(w);
    chk("iso_grant", 32'(grant), 32'h8);
    @(posedge Clk); #1 a[31:24] = 8'd1;
    req[3] = 1'b0;
    wait_done(w);
    chk("iso_winner", 32'(w), 32'd3);
    // reset during the first EXEC cycle
    set_op(0, 50, 5);
    @(posedge Clk); #1 req = 4'b0001;
    wait_grant(w);
    chk("mid_grant", 32'(grant), 32'h1);
    Rst = 1'b1;
    req = 4'b0;
    @(posedge Clk); #1 Rst = 1'b0;
    @(negedge Clk);
    chk_zero("mid_rst");
    chk("mid_quot", 32'(quot), 32'd0);
    chk("mid_dz", 32'(dz), 32'd0);
    set_op(1, 77, 7); set_op(3, 90, 4);
    push(1, 11, 0); push(3, 22, 0);
    @(posedge Clk); #1 req = 4'b1010;
    wait_done(w);
    chk("mid_first", 32'(w), 32'd1);
    @(posedge Clk); #1 req[1] = 1'b0;
    wait_done(w);
    chk("mid_second", 32'(w), 32'd3);
    @(posedge Clk); #1 req = 4'b0;
    repeat (6) @(negedge Clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk_zero("end_idle");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
